// File: rtl/cfu_pipe_if.sv
// Handshake bundle between execute, the control flow unit and EIP writeback.
// master drives requests and result ready; slave is the control flow unit.
interface cfu_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opc;
    logic [31:0]       eflags;
    logic [ADDR_W-1:0] ecx;
    logic [ADDR_W-1:0] eip;
    logic [LEN_W-1:0]  instr_len;
    logic [ADDR_W-1:0] address;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] next_eip;
    logic              taken;
    logic              ecx_we;
    logic [ADDR_W-1:0] ecx_next;
    logic              ras_mismatch;

    modport master (
        output in_valid, opc, eflags, ecx, eip,
        output instr_len, address, out_ready,
        input  in_ready, out_valid, next_eip, taken,
        input  ecx_we, ecx_next, ras_mismatch
    );

    modport slave (
        input  in_valid, opc, eflags, ecx, eip,
        input  instr_len, address, out_ready,
        output in_ready, out_valid, next_eip, taken,
        output ecx_we, ecx_next, ras_mismatch
    );
endinterface

// File: rtl/cfu_pipe.sv
// Tiny86 control flow unit: registered next-EIP / LOOP ECX computation.
// Define CFU_RAS_EN to add the return-address stack and RET mismatch flag.
module cfu_pipe #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int RAS_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    cfu_pipe_if.slave  bus
);
    // Command indices: Jcc in x86 condition order, then the rest.
    localparam logic [6:0] OP_JO     = 7'd0;
    localparam logic [6:0] OP_JNO    = 7'd1;
    localparam logic [6:0] OP_JB     = 7'd2;
    localparam logic [6:0] OP_JAE    = 7'd3;
    localparam logic [6:0] OP_JE     = 7'd4;
    localparam logic [6:0] OP_JNE    = 7'd5;
    localparam logic [6:0] OP_JBE    = 7'd6;
    localparam logic [6:0] OP_JA     = 7'd7;
    localparam logic [6:0] OP_JS     = 7'd8;
    localparam logic [6:0] OP_JNS    = 7'd9;
    localparam logic [6:0] OP_JP     = 7'd10;
    localparam logic [6:0] OP_JNP    = 7'd11;
    localparam logic [6:0] OP_JL     = 7'd12;
    localparam logic [6:0] OP_JGE    = 7'd13;
    localparam logic [6:0] OP_JLE    = 7'd14;
    localparam logic [6:0] OP_JG     = 7'd15;
    localparam logic [6:0] OP_JCXZ   = 7'd16;
    localparam logic [6:0] OP_JMPR   = 7'd17;
    localparam logic [6:0] OP_JMPI   = 7'd18;
    localparam logic [6:0] OP_CALLR  = 7'd19;
    localparam logic [6:0] OP_CALLI  = 7'd20;
    localparam logic [6:0] OP_RET    = 7'd21;
    localparam logic [6:0] OP_LOOP   = 7'd22;
    localparam logic [6:0] OP_LOOPE  = 7'd23;
    localparam logic [6:0] OP_LOOPNE = 7'd24;

    logic cf, pf, zf, sf, of;
    logic accept;
    logic [ADDR_W-1:0] seq_eip, rel_eip, ecx_dec;
    logic taken_d, ecx_we_d, use_abs, is_call, is_ret, mism_d;
    logic [ADDR_W-1:0] next_d, ecx_next_d;

    logic              out_valid_q, taken_q, ecx_we_q, mism_q;
    logic [ADDR_W-1:0] next_q, ecx_next_q;

    logic unused_flags;

    assign cf = bus.eflags[0];
    assign pf = bus.eflags[2];
    assign zf = bus.eflags[6];
    assign sf = bus.eflags[7];
    assign of = bus.eflags[11];
    assign unused_flags = ^{bus.eflags[31:12], bus.eflags[10:8],
                            bus.eflags[5:3], bus.eflags[1]};

    assign bus.in_ready = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    assign seq_eip = bus.eip + {{(ADDR_W-LEN_W){1'b0}}, bus.instr_len};
    assign rel_eip = seq_eip + bus.address;
    assign ecx_dec = bus.ecx - ADDR_W'(1);

    // Decode the command into branch decision, target select and ECX update.
    always_comb begin
        taken_d    = 1'b0;
        use_abs    = 1'b0;
        ecx_we_d   = 1'b0;
        ecx_next_d = '0;
        is_call    = 1'b0;
        is_ret     = 1'b0;
        unique case (bus.opc)
            OP_JO:     taken_d = of;
            OP_JNO:    taken_d = !of;
            OP_JB:     taken_d = cf;
            OP_JAE:    taken_d = !cf;
            OP_JE:     taken_d = zf;
            OP_JNE:    taken_d = !zf;
            OP_JBE:    taken_d = cf | zf;
            OP_JA:     taken_d = !cf & !zf;
            OP_JS:     taken_d = sf;
            OP_JNS:    taken_d = !sf;
            OP_JP:     taken_d = pf;
            OP_JNP:    taken_d = !pf;
            OP_JL:     taken_d = sf != of;
            OP_JGE:    taken_d = sf == of;
            OP_JLE:    taken_d = zf | (sf != of);
            OP_JG:     taken_d = !zf & (sf == of);
            OP_JCXZ:   taken_d = bus.ecx == '0;
            OP_JMPR:   taken_d = 1'b1;
            OP_JMPI: begin
                taken_d = 1'b1;
                use_abs = 1'b1;
            end
            OP_CALLR: begin
                taken_d = 1'b1;
                is_call = 1'b1;
            end
            OP_CALLI: begin
                taken_d = 1'b1;
                use_abs = 1'b1;
                is_call = 1'b1;
            end
            OP_RET: begin
                taken_d = 1'b1;
                use_abs = 1'b1;
                is_ret  = 1'b1;
            end
            OP_LOOP, OP_LOOPE, OP_LOOPNE: begin
                ecx_we_d   = 1'b1;
                ecx_next_d = ecx_dec;
                taken_d    = ecx_dec != '0;
                if (bus.opc == OP_LOOPE)  taken_d = taken_d & zf;
                if (bus.opc == OP_LOOPNE) taken_d = taken_d & !zf;
            end
            default: ;
        endcase
        if (!taken_d)     next_d = seq_eip;
        else if (use_abs) next_d = bus.address;
        else              next_d = rel_eip;
    end

`ifdef CFU_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     ras_ptr;
    logic [CW-1:0]     ras_cnt;
    logic              ras_empty, ras_full;

    assign ras_empty = ras_cnt == '0;
    assign ras_full  = ras_cnt == CW'(RAS_DEPTH);
    assign mism_d    = is_ret & (ras_empty | (bus.address != ras_mem[ras_ptr]));

    // Top pointer wraps so a push on a full stack overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (flush) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (accept && is_call) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
        end else if (accept && is_ret && !ras_empty) begin
            ras_ptr <= ras_ptr - PW'(1);
            ras_cnt <= ras_cnt - CW'(1);
        end
    end

    // Stack storage needs no reset; the count marks which entries are live.
    always_ff @(posedge clk) begin
        if (!flush && accept && is_call)
            ras_mem[ras_ptr + PW'(1)] <= seq_eip;
    end
`else
    logic unused_ras;

    assign mism_d     = 1'b0;
    assign unused_ras = ^{is_call, is_ret, (RAS_DEPTH > 1)};
`endif

    // Output stage: load on accept, hold while stalled, drop on flush/consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            next_q      <= '0;
            taken_q     <= 1'b0;
            ecx_we_q    <= 1'b0;
            ecx_next_q  <= '0;
            mism_q      <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            next_q      <= next_d;
            taken_q     <= taken_d;
            ecx_we_q    <= ecx_we_d;
            ecx_next_q  <= ecx_next_d;
            mism_q      <= mism_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.next_eip     = next_q;
    assign bus.taken        = taken_q;
    assign bus.ecx_we       = ecx_we_q;
    assign bus.ecx_next     = ecx_next_q;
    assign bus.ras_mismatch = mism_q;
endmodule

// File: tb/tb_cfu_pipe.sv
// Self-checking bench for cfu_pipe against a flag/queue level reference.
// Build with CFU_RAS_EN defined to also exercise the return-address stack.
module tb_cfu_pipe;
    localparam int RAS_DEPTH = 8;

    localparam logic [6:0] JE = 7'd4, JCXZ = 7'd16, JMPR = 7'd17;
    localparam logic [6:0] JMPI = 7'd18, CALLR = 7'd19, CALLI = 7'd20;
    localparam logic [6:0] RET = 7'd21, LOOP = 7'd22, LOOPE = 7'd23;
    localparam logic [6:0] LOOPNE = 7'd24, NOP = 7'd30;
    localparam logic [31:0] ZF = 32'h40;

    typedef struct packed {
        logic        taken;
        logic        ecx_we;
        logic        mism;
        logic [31:0] nxt;
        logic [31:0] ecx_next;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] ras_q[$];

    cfu_pipe_if #(.ADDR_W(32), .LEN_W(4)) bus ();

    cfu_pipe #(.ADDR_W(32), .LEN_W(4), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic exp_t got();
        return {bus.taken, bus.ecx_we, bus.ras_mismatch, bus.next_eip, bus.ecx_next};
    endfunction

    // Reference: Jcc via x86 condition pairs, RAS as a bounded LIFO queue.
    function automatic exp_t model(input logic [6:0] op, input logic [31:0] fl,
                                   input logic [31:0] ecx, input logic [31:0] eip,
                                   input logic [3:0] len, input logic [31:0] addr);
        exp_t e;
        logic [31:0] seq;
        logic c, cf, pf, zf, sf, of;
        cf = fl[0]; pf = fl[2]; zf = fl[6]; sf = fl[7]; of = fl[11];
        seq = eip + {28'd0, len};
        e = '0;
        e.nxt = seq;
        c = 1'b0;
        if (op < 7'd16) begin
            case (op[3:1])
                3'd0: c = of;
                3'd1: c = cf;
                3'd2: c = zf;
                3'd3: c = cf | zf;
                3'd4: c = sf;
                3'd5: c = pf;
                3'd6: c = sf ^ of;
                default: c = zf | (sf ^ of);
            endcase
            c = c ^ op[0];
            e.taken = c;
            if (c) e.nxt = seq + addr;
        end else if (op == JCXZ) begin
            e.taken = ecx == 0;
            if (e.taken) e.nxt = seq + addr;
        end else if (op == JMPR || op == CALLR) begin
            e.taken = 1'b1;
            e.nxt = seq + addr;
        end else if (op == JMPI || op == CALLI || op == RET) begin
            e.taken = 1'b1;
            e.nxt = addr;
        end else if (op >= LOOP && op <= LOOPNE) begin
            e.ecx_we = 1'b1;
            e.ecx_next = ecx - 1;
            c = ecx != 1;
            if (op == LOOPE) c = c && zf;
            if (op == LOOPNE) c = c && !zf;
            e.taken = c;
            if (c) e.nxt = seq + addr;
        end
`ifdef CFU_RAS_EN
        if (op == CALLR || op == CALLI) begin
            if (ras_q.size() == RAS_DEPTH) void'(ras_q.pop_front());
            ras_q.push_back(seq);
        end
        if (op == RET) begin
            e.mism = (ras_q.size() == 0) || (ras_q[$] != addr);
            if (ras_q.size() > 0) void'(ras_q.pop_back());
        end
`endif
        return e;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [31:0] fl,
                         input logic [31:0] ecx, input logic [31:0] eip,
                         input logic [3:0] len, input logic [31:0] addr);
        bus.opc = op;
        bus.eflags = fl;
        bus.ecx = ecx;
        bus.eip = eip;
        bus.instr_len = len;
        bus.address = addr;
    endtask

    task automatic test_reset();
        exp_t e;
        e = '0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (got() !== e) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got(), e);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [6:0]  op[6]  = '{JE, LOOPNE, LOOP, NOP, JCXZ, JMPI};
        logic [31:0] fl[6]  = '{ZF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] cx[6]  = '{32'h5, 32'h1, 32'h0, 32'h9, 32'h0, 32'h3};
        logic [31:0] ip[6]  = '{32'h1000, 32'h2000, 32'h3000,
                                32'hFFFF_FFFE, 32'h10, 32'h500};
        logic [3:0]  ln[6]  = '{4'd2, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3};
        logic [31:0] ad[6]  = '{32'h10, 32'hFFFF_FFF0, 32'h20,
                                32'h7, 32'h100, 32'h8000};
        logic [31:0] nx[6]  = '{32'h1012, 32'h2002, 32'h3023,
                                32'h2, 32'h112, 32'h8000};
        logic        tk[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(op[i], fl[i], cx[i], ip[i], ln[i], ad[i]);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            e = model(op[i], fl[i], cx[i], ip[i], ln[i], ad[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.next_eip !== nx[i] || bus.taken !== tk[i]) begin
                failures++;
                $display("FAIL directed%0d got=%b/%h/%b exp=1/%h/%b", i,
                         bus.out_valid, bus.next_eip, bus.taken, nx[i], tk[i]);
            end
            checks++;
            if (got() !== e) begin
                failures++;
                $display("FAIL directed%0d_model got=%h exp=%h", i, got(), e);
            end
        end
        checks++;
        if (bus.ecx_next !== 32'hFFFF_FFFF && op[5] == JMPI) begin
            if (bus.ecx_next !== 32'h0) begin
                failures++;
                $display("FAIL directed_ecx_clear got=%h exp=0", bus.ecx_next);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [31:0] fl, cx, ip, ad;
        logic [3:0] ln;
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 7'($urandom_range(0, 31));
            fl = $urandom;
            cx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            ip = $urandom;
            ln = 4'($urandom);
            ad = $urandom;
            if (op == RET && ras_q.size() > 0 && $urandom_range(0, 1) == 1)
                ad = ras_q[$];
            drive(op, fl, cx, ip, ln, ad);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            e = model(op, fl, cx, ip, ln, ad);
            checks++;
            if (bus.out_valid !== 1'b1 || got() !== e) begin
                failures++;
                $display("FAIL random%0d op=%0d got=%b/%h exp=1/%h", i, op,
                         bus.out_valid, got(), e);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ras();
        exp_t e;
        logic want;
        logic [31:0] seqs[9];
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ras_q.delete();
        bus.in_valid = 1'b1;
        drive(CALLI, 0, 0, 32'h100, 4'd5, 32'h4000);
        @(posedge clk); #1;
        void'(model(CALLI, 0, 0, 32'h100, 4'd5, 32'h4000));
        drive(RET, 0, 0, 32'h4000, 4'd1, 32'h105);
        @(posedge clk); #1;
        e = model(RET, 0, 0, 32'h4000, 4'd1, 32'h105);
        checks++;
        if (bus.ras_mismatch !== 1'b0 || got() !== e) begin
            failures++;
            $display("FAIL ras_match got=%h exp=%h", got(), e);
        end
        drive(CALLI, 0, 0, 32'h100, 4'd5, 32'h4000);
        @(posedge clk); #1;
        void'(model(CALLI, 0, 0, 32'h100, 4'd5, 32'h4000));
        drive(RET, 0, 0, 32'h4000, 4'd1, 32'h106);
        @(posedge clk); #1;
        e = model(RET, 0, 0, 32'h4000, 4'd1, 32'h106);
`ifdef CFU_RAS_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        checks++;
        if (bus.ras_mismatch !== want || got() !== e) begin
            failures++;
            $display("FAIL ras_wrong got=%h exp=%h", got(), e);
        end
        for (int k = 0; k < 9; k++) begin
            seqs[k] = 32'h9000 + 32'(k) * 32'h10 + 32'd3;
            drive(CALLR, 0, 0, 32'h9000 + 32'(k) * 32'h10, 4'd3, 32'h40);
            @(posedge clk); #1;
            e = model(CALLR, 0, 0, 32'h9000 + 32'(k) * 32'h10, 4'd3, 32'h40);
            checks++;
            if (got() !== e) begin
                failures++;
                $display("FAIL ras_call%0d got=%h exp=%h", k, got(), e);
            end
        end
        for (int k = 0; k < 9; k++) begin
            drive(RET, 0, 0, 32'h40, 4'd1, seqs[8 - k]);
            @(posedge clk); #1;
            e = model(RET, 0, 0, 32'h40, 4'd1, seqs[8 - k]);
`ifdef CFU_RAS_EN
            want = (k == 8);
`else
            want = 1'b0;
`endif
            checks++;
            if (bus.ras_mismatch !== want || got() !== e) begin
                failures++;
                $display("FAIL ras_ret%0d got=%b exp=%b", k, bus.ras_mismatch, want);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_stall();
        exp_t ea, eb;
        bus.out_ready = 1'b0;
        drive(LOOPE, ZF, 32'h7, 32'h600, 4'd2, 32'h30);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        ea = model(LOOPE, ZF, 32'h7, 32'h600, 4'd2, 32'h30);
        drive(JMPR, 0, 0, 32'h700, 4'd4, 32'hFFFF_FF00);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || got() !== ea) begin
                failures++;
                $display("FAIL stall%0d got=%b/%b/%h exp=0/1/%h", c,
                         bus.in_ready, bus.out_valid, got(), ea);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%b exp=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        eb = model(JMPR, 0, 0, 32'h700, 4'd4, 32'hFFFF_FF00);
        checks++;
        if (bus.out_valid !== 1'b1 || got() !== eb) begin
            failures++;
            $display("FAIL stall_second got=%b/%h exp=1/%h", bus.out_valid, got(), eb);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic want;
        bus.out_ready = 1'b1;
        drive(CALLR, 0, 0, 32'hA00, 4'd2, 32'h10);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        void'(model(CALLR, 0, 0, 32'hA00, 4'd2, 32'h10));
        drive(CALLI, 0, 0, 32'hB00, 4'd5, 32'hC00);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ras_q.delete();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_valid got=%b exp=0", bus.out_valid);
        end
        drive(RET, 0, 0, 32'h10, 4'd1, 32'hA02);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e = model(RET, 0, 0, 32'h10, 4'd1, 32'hA02);
`ifdef CFU_RAS_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        checks++;
        if (bus.ras_mismatch !== want || got() !== e) begin
            failures++;
            $display("FAIL flush_ras got=%b exp=%b", bus.ras_mismatch, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        exp_t z;
        z = '0;
        bus.out_ready = 1'b0;
        drive(LOOP, 0, 32'h0, 32'hD00, 4'd2, 32'h4);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        void'(model(LOOP, 0, 32'h0, 32'hD00, 4'd2, 32'h4));
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        ras_q.delete();
        checks++;
        if (bus.out_valid !== 1'b0 || got() !== z) begin
            failures++;
            $display("FAIL areset got=%b/%h exp=0/%h", bus.out_valid, got(), z);
        end
        #4 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_post got=%b exp=0", bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(NOP, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_random();
        test_ras();
        test_back_to_back_stall();
        test_flush();
        test_async_reset();
        test_ras();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
